// File: rtl/sync_time_loader.sv
// sync_time_loader: free-running BCD hh:mm:ss timekeeper with a validated valid/ready load port.
// Optional macro SYNC_PHASE_EN: a successful load also restarts the seconds prescaler.
module sync_time_loader #(
  parameter int CLOCK_FREQ = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [23:0] load_time,
  output logic        load_ack,
  output logic        load_err,
  output logic [23:0] time_value,
  output logic        tick_sec,
  output logic        day_wrap
);

  localparam int DATA_W  = 24;
  localparam int PRESC_W = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLOCK_FREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                accept;
  logic                apply_en;
  logic                apply_ok;
  logic [DATA_W-1:0]   shadow_p0;
  logic                ok_p1;
  logic [PRESC_W-1:0]  presc;
  logic                presc_wrap;
  logic [DATA_W-1:0]   inc_time;
  logic                inc_wrap;

  // Packing is {sec1, sec10, min1, min10, hour1, hour10}, sec1 in the top nibble.
  function automatic logic time_ok(input logic [DATA_W-1:0] t);
    logic [3:0] s1, s10, m1, m10, h1, h10;
    {s1, s10, m1, m10, h1, h10} = t;
    return (s1 <= 4'd9) && (s10 <= 4'd5) &&
           (m1 <= 4'd9) && (m10 <= 4'd5) &&
           (h1 <= 4'd9) && (h10 <= 4'd2) &&
           !((h10 == 4'd2) && (h1 > 4'd3));
  endfunction

  // One-second increment with full carry ripple; MSB of the result flags the day wrap.
  function automatic logic [DATA_W:0] time_inc(input logic [DATA_W-1:0] t);
    logic [3:0] s1, s10, m1, m10, h1, h10;
    logic       wrap;
    {s1, s10, m1, m10, h1, h10} = t;
    wrap = 1'b0;
    if (s1 != 4'd9) begin
      s1 = s1 + 4'd1;
    end else begin
      s1 = 4'd0;
      if (s10 != 4'd5) begin
        s10 = s10 + 4'd1;
      end else begin
        s10 = 4'd0;
        if (m1 != 4'd9) begin
          m1 = m1 + 4'd1;
        end else begin
          m1 = 4'd0;
          if (m10 != 4'd5) begin
            m10 = m10 + 4'd1;
          end else begin
            m10 = 4'd0;
            if ((h10 == 4'd2) && (h1 == 4'd3)) begin
              h10  = 4'd0;
              h1   = 4'd0;
              wrap = 1'b1;
            end else if (h1 == 4'd9) begin
              h1  = 4'd0;
              h10 = h10 + 4'd1;
            end else begin
              h1 = h1 + 4'd1;
            end
          end
        end
      end
    end
    return {wrap, s1, s10, m1, m10, h1, h10};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_valid) state_next = CHECK;
      CHECK:   state_next = APPLY;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    apply_en   = 1'b0;
    case (state)
      IDLE:    load_ready = 1'b1;
      APPLY:   apply_en   = 1'b1;
      default: ;
    endcase
  end

  assign accept   = load_valid & load_ready;
  assign apply_ok = apply_en & ok_p1;

  // Stage p0: capture the offered word in the shadow register.
  always_ff @(posedge clk) begin
    if (accept) begin
      shadow_p0 <= load_time;
    end
  end

  // Stage p1: register the range check so APPLY only sees a flop.
  always_ff @(posedge clk) begin
    if (state == CHECK) begin
      ok_p1 <= time_ok(shadow_p0);
    end
  end

  assign presc_wrap           = (presc == PRESC_MAX);
  assign {inc_wrap, inc_time} = time_inc(time_value);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else begin
      if (presc_wrap) begin
        presc <= '0;
      end else begin
        presc <= presc + PRESC_W'(1);
      end
`ifdef SYNC_PHASE_EN
      if (apply_ok) begin
        presc <= '0;
      end
`endif
    end
  end

  // Stage p2: a valid load overrides (and swallows) a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      time_value <= '0;
      tick_sec   <= 1'b0;
      day_wrap   <= 1'b0;
      load_ack   <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      load_ack <= apply_ok;
      load_err <= apply_en & ~ok_p1;
      if (apply_ok) begin
        time_value <= shadow_p0;
        tick_sec   <= 1'b0;
        day_wrap   <= 1'b0;
      end else if (presc_wrap) begin
        time_value <= inc_time;
        tick_sec   <= 1'b1;
        day_wrap   <= inc_wrap;
      end else begin
        tick_sec   <= 1'b0;
        day_wrap   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_time_loader.sv
// Randomized scoreboard bench for sync_time_loader against a seconds-of-day reference model.
module tb_sync_time_loader;

  localparam int CF = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [23:0] load_time = 24'h0;
  logic        load_ready;
  logic        load_ack;
  logic        load_err;
  logic [23:0] time_value;
  logic        tick_sec;
  logic        day_wrap;

  always #5 clk = ~clk;

  sync_time_loader #(.CLOCK_FREQ(CF)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_time  (load_time),
    .load_ack   (load_ack),
    .load_err   (load_err),
    .time_value (time_value),
    .tick_sec   (tick_sec),
    .day_wrap   (day_wrap)
  );

  int checks = 0;
  int failures = 0;

  int          m_secs = 0;
  int          m_presc = 0;
  int          m_cnt = 0;
  logic [23:0] m_pend = 24'h0;
  bit          m_tick = 0, m_wrap = 0, m_ack = 0, m_err = 0;
  bit          armed = 0;
  logic [23:0] sb_q[$];

  function automatic bit is_legal(input logic [23:0] w);
    int s1, s10, m1, m10, h1, h10;
    s1  = int'(w[23:20]);  s10 = int'(w[19:16]);
    m1  = int'(w[15:12]);  m10 = int'(w[11:8]);
    h1  = int'(w[7:4]);    h10 = int'(w[3:0]);
    if (s1 > 9 || s10 > 9 || m1 > 9 || m10 > 9 || h1 > 9 || h10 > 9) return 0;
    return (s10 * 10 + s1 < 60) && (m10 * 10 + m1 < 60) && (h10 * 10 + h1 < 24);
  endfunction

  function automatic int to_secs(input logic [23:0] w);
    int ss, mm, hh;
    ss = int'(w[19:16]) * 10 + int'(w[23:20]);
    mm = int'(w[11:8]) * 10 + int'(w[15:12]);
    hh = int'(w[3:0]) * 10 + int'(w[7:4]);
    return hh * 3600 + mm * 60 + ss;
  endfunction

  function automatic logic [23:0] to_bcd(input int s);
    int ss, mm, hh;
    ss = s % 60;
    mm = (s / 60) % 60;
    hh = s / 3600;
    return {4'(ss % 10), 4'(ss / 10), 4'(mm % 10), 4'(mm / 10), 4'(hh % 10), 4'(hh / 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time as seconds of day, load seen two edges after its handshake.
  initial begin
    bit tick_now, apply_now;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_secs = 0; m_presc = 0; m_cnt = 0;
        m_tick = 0; m_wrap = 0; m_ack = 0; m_err = 0;
        armed = 1;
      end else begin
        tick_now  = (m_presc == CF - 1);
        apply_now = (m_cnt == 1);
        m_presc   = tick_now ? 0 : m_presc + 1;
        m_tick = 0; m_wrap = 0; m_ack = 0; m_err = 0;
        if (apply_now && is_legal(m_pend)) begin
          m_secs = to_secs(m_pend);
          m_ack  = 1;
`ifdef SYNC_PHASE_EN
          m_presc = 0;
`endif
        end else begin
          if (apply_now) m_err = 1;
          if (tick_now) begin
            m_tick = 1;
            m_secs++;
            if (m_secs == 86400) begin
              m_secs = 0;
              m_wrap = 1;
            end
          end
        end
        if (m_cnt > 0) m_cnt--;
        else if (load_valid) begin
          m_pend = load_time;
          m_cnt  = 2;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        check("time_value", 32'(time_value), 32'(to_bcd(m_secs)));
        check("tick_sec",   32'(tick_sec),   32'(m_tick));
        check("day_wrap",   32'(day_wrap),   32'(m_wrap));
        check("load_ack",   32'(load_ack),   32'(m_ack));
        check("load_err",   32'(load_err),   32'(m_err));
        check("load_ready", 32'(load_ready), 32'(m_cnt == 0));
      end
    end
  end

  // Scoreboard monitor: each ack/err consumes the oldest issued word.
  initial begin
    logic [23:0] exp_w;
    forever begin
      @(negedge clk);
      if (armed && (load_ack || load_err)) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual ack=%0b err=%0b required=no response at %0t",
                   load_ack, load_err, $time);
        end else begin
          exp_w = sb_q.pop_front();
          check("sb_kind", 32'(load_ack), 32'(is_legal(exp_w)));
          if (load_ack) check("sb_time", 32'(time_value), 32'(exp_w));
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise valid immediately and hold it until the DUT is ready.
  task automatic issue(input logic [23:0] w);
    int n = 0;
    @(negedge clk);
    load_valid = 1'b1;
    load_time  = w;
    sb_q.push_back(w);
    while (!load_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 50), 32'd1);
    @(negedge clk);
    load_valid = 1'b0;
    load_time  = 24'($urandom());
  endtask

  // Offer the word only when the prescaler sits at the given phase.
  task automatic issue_at(input logic [23:0] w, input int phase);
    int n = 0;
    @(negedge clk);
    while (!(load_ready && m_presc == phase) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("phase_wait", 32'(n < 100), 32'd1);
    load_valid = 1'b1;
    load_time  = w;
    sb_q.push_back(w);
    @(negedge clk);
    load_valid = 1'b0;
    load_time  = 24'($urandom());
  endtask

  // Accept a word, then reset after `delay` more cycles (0 = during CHECK, 1 = during APPLY).
  task automatic issue_then_reset(input logic [23:0] w, input int delay);
    int n = 0;
    @(negedge clk);
    while (!load_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait_rst", 32'(n < 50), 32'd1);
    load_valid = 1'b1;
    load_time  = w;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (delay) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int r;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_cycles(12);

    issue(24'h654321);
    wait_cycles(14);
    issue(24'h959532);
    wait_cycles(12);

    issue(24'h000042);
    issue(24'h064321);
    issue(24'h0000A0);
    wait_cycles(12);

    issue_at(24'h000021, 7);
    wait_cycles(14);
    issue_at(24'h959532, 7);
    wait_cycles(8);
    issue_at(24'h000000, 7);
    wait_cycles(12);
    issue_at(24'h0000A0, 7);
    wait_cycles(12);

    issue(24'h958512);
    wait_cycles(5);
    issue_then_reset(24'h654321, 0);
    wait_cycles(12);
    issue_then_reset(24'h000021, 1);
    wait_cycles(12);

    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0: issue(to_bcd(int'($urandom_range(0, 86399))));
        1: issue(24'($urandom()));
        2: issue(to_bcd(int'($urandom_range(86390, 86399))));
        default: issue_at(to_bcd(int'($urandom_range(0, 86399))), int'($urandom_range(0, CF - 1)));
      endcase
      wait_cycles(int'($urandom_range(0, 12)));
    end

    wait_cycles(20);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
